// File: rtl/cpu4_prog_sequencer.sv
// cpu4_prog_sequencer: host-side controller for the 4-bit accumulator core.
// Loads a 16-nibble image (8 code, then 8 data) from a valid/ready stream,
// runs the core for a bounded number of cycles and latches the final pc/acc.
// Optional build macro: CPU4_SEQ_HALT_DETECT_EN (ends RUN early on a
// Bz-to-self halt, reported on 'halted').
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle session start (honoured in IDLE/DONE)
//   start_pc, run_limit entry pc and Run-cycle limit (0 = 2**CNT_W)
//   in_valid/in_ready/in_data  image nibble stream
//   cpu_ui              core command bus {arg, 0, cmd, 0}
//   cpu_pc, cpu_acc     observed core state
//   busy, done, halted  session status
//   result_pc/acc       captured core state; run_cycles = Run commands issued
module cpu4_prog_sequencer #(
  parameter int unsigned PC_W  = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  input  logic [CNT_W-1:0] run_limit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic [7:0]       cpu_ui,
  input  logic [PC_W-1:0]  cpu_pc,
  input  logic [3:0]       cpu_acc,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic [PC_W-1:0]  result_pc,
  output logic [3:0]       result_acc,
  output logic [CNT_W-1:0] run_cycles
);

  localparam logic [1:0] CMD_RESET = 2'd0;
  localparam logic [1:0] CMD_LCODE = 2'd1;
  localparam logic [1:0] CMD_LDATA = 2'd2;
  localparam logic [1:0] CMD_RUN   = 2'd3;
  localparam logic [PC_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST0, S_CODE, S_DATA, S_RST1, S_RUN, S_CAPT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  idx_q;
  logic [PC_W-1:0]  start_pc_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim_m1_c;
  logic [1:0]       cmd_c;
  logic [3:0]       arg_c;

`ifdef CPU4_SEQ_HALT_DETECT_EN
  logic [PC_W-1:0]  prev_pc_q;
  logic             run_seen_q;
  logic             halted_q;
  logic             halt_hit_c;
`endif

  // Last Run index; run_limit=0 wraps to all-ones, giving 2**CNT_W cycles.
  assign lim_m1_c = limit_q - CNT_W'(1);
  assign cpu_ui   = {arg_c, 1'b0, cmd_c, 1'b0};

  // Next state and core command bus; the sequencer drives every bus cycle.
  always_comb begin
    state_d  = state_q;
    cmd_c    = CMD_RESET;
    arg_c    = 4'd0;
    in_ready = 1'b0;
`ifdef CPU4_SEQ_HALT_DETECT_EN
    halt_hit_c = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RST0;
      S_RST0: state_d = S_CODE;
      S_CODE, S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cmd_c = (state_q == S_CODE) ? CMD_LCODE : CMD_LDATA;
          arg_c = in_data;
          if (idx_q == IDX_LAST) state_d = (state_q == S_CODE) ? S_DATA : S_RST1;
        end else begin
          // Stall: Reset to the current index keeps the core pc in place.
          arg_c = 4'(idx_q);
        end
      end
      S_RST1: begin
        arg_c   = 4'(start_pc_q);
        state_d = S_RUN;
      end
      S_RUN: begin
        cmd_c = CMD_RUN;
        if (cnt_q == lim_m1_c) state_d = S_CAPT;
`ifdef CPU4_SEQ_HALT_DETECT_EN
        // Only a taken Bz-to-self leaves pc unchanged across a Run.
        if (run_seen_q && (cpu_pc == prev_pc_q)) begin
          halt_hit_c = 1'b1;
          state_d    = S_CAPT;
        end
`endif
      end
      S_CAPT:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      cmd_c    = CMD_RESET;
      arg_c    = 4'd0;
      in_ready = 1'b0;
    end
  end

  // State, session registers and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      start_pc_q <= '0;
      limit_q    <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_pc  <= '0;
      result_acc <= '0;
      run_cycles <= '0;
`ifdef CPU4_SEQ_HALT_DETECT_EN
      prev_pc_q  <= '0;
      run_seen_q <= 1'b0;
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d inside {S_RST0, S_CODE, S_DATA, S_RST1, S_RUN, S_CAPT});
      done    <= (state_d == S_DONE);
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          start_pc_q <= start_pc;
          limit_q    <= run_limit;
          run_cycles <= '0;
`ifdef CPU4_SEQ_HALT_DETECT_EN
          halted_q   <= 1'b0;
`endif
        end
        S_RST0: idx_q <= '0;
        S_CODE, S_DATA: if (in_valid) idx_q <= idx_q + PC_W'(1);
        S_RST1: begin
          cnt_q <= '0;
`ifdef CPU4_SEQ_HALT_DETECT_EN
          run_seen_q <= 1'b0;
`endif
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
`ifdef CPU4_SEQ_HALT_DETECT_EN
          prev_pc_q  <= cpu_pc;
          run_seen_q <= 1'b1;
          if (halt_hit_c) halted_q <= 1'b1;
`endif
        end
        S_CAPT: begin
          result_pc  <= cpu_pc;
          result_acc <= cpu_acc;
          run_cycles <= cnt_q;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU4_SEQ_HALT_DETECT_EN
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu4_prog_sequencer.sv
// Self-checking bench for cpu4_prog_sequencer with a behavioural model of the
// 4-bit accumulator core (Load=0, Add=2, Bz=3 on instr[1:0]; Bz stays put
// when acc==0). Expected session results are queued at start and checked
// when done rises.
module tb_cpu4_prog_sequencer;
  localparam int unsigned PC_W  = 3;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [PC_W-1:0]  start_pc = '0;
  logic [CNT_W-1:0] run_limit = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_data = '0;
  logic [7:0]       cpu_ui;
  logic [PC_W-1:0]  cpu_pc;
  logic [3:0]       cpu_acc;
  logic             busy, done, halted;
  logic [PC_W-1:0]  result_pc;
  logic [3:0]       result_acc;
  logic [CNT_W-1:0] run_cycles;

  cpu4_prog_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .run_limit(run_limit), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cpu_ui(cpu_ui), .cpu_pc(cpu_pc), .cpu_acc(cpu_acc),
    .busy(busy), .done(done), .halted(halted), .result_pc(result_pc),
    .result_acc(result_acc), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model driven by the command bus.
  logic [3:0] code_m [8];
  logic [3:0] data_m [8];
  logic [2:0] m_pc = '0;
  logic [3:0] m_acc = '0;
  assign cpu_pc  = m_pc;
  assign cpu_acc = m_acc;

  always @(posedge clk) begin
    case (cpu_ui[2:1])
      2'd0: begin m_pc <= cpu_ui[6:4]; m_acc <= 4'd0; end
      2'd1: begin code_m[m_pc] <= cpu_ui[7:4]; m_pc <= m_pc + 3'd1; end
      2'd2: begin data_m[m_pc] <= cpu_ui[7:4]; m_pc <= m_pc + 3'd1; end
      default: begin
        case (code_m[m_pc][1:0])
          2'd0: begin m_acc <= data_m[m_pc]; m_pc <= m_pc + 3'd1; end
          2'd2: begin m_acc <= m_acc + data_m[m_pc]; m_pc <= m_pc + 3'd1; end
          2'd3: if (m_acc != 4'd0) m_pc <= m_pc + 3'd1;
          default: m_pc <= m_pc + 3'd1;
        endcase
      end
    endcase
  end

  typedef struct {
    logic [2:0] pc;
    logic [3:0] acc;
    logic [7:0] cycles;
    logic       halt;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] img [16];
  int         nchk = 0;
  int         nfail = 0;
  int         sc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_add();
    for (int i = 0; i < 16; i++) img[i] = (i < 8) ? 4'd2 : 4'd1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) img[i] = 4'd0;
    img[1] = 4'd3;
    img[9] = 4'd1;
  endtask

  task automatic push_exp(input logic [2:0] pc, input logic [3:0] acc,
                          input logic [7:0] cycles, input logic halt, input int lat);
    exp_t e;
    e.pc = pc; e.acc = acc; e.cycles = cycles; e.halt = halt; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [2:0] pc, input logic [7:0] lim);
    start = 1'b1; start_pc = pc; run_limit = lim;
    step();
    start = 1'b0;
    sc = cyc;
  endtask

  // Streams img[0..nmax-1]; optional 'slen'-cycle stalls after accepts sa/sb2.
  task automatic feed(input int nmax, input int sa, input int sb2, input int slen,
                      input bit extra_start);
    int n = 0;
    int g = 0;
    int st = 0;
    while (n < nmax && g < 200) begin
      if (st > 0) begin
        in_valid = 1'b0;
        #1;
        chk("stall_ui", 32'(cpu_ui), 32'({1'b0, 3'(n % 8), 4'b0000}));
        chk("stall_rdy", 32'(in_ready), 32'd1);
        st--;
      end else begin
        in_valid = 1'b1;
        in_data  = img[n];
        start    = extra_start && (n == 4);
        #1;
        if (in_ready) begin
          chk("load_ui", 32'(cpu_ui), 32'({img[n], 1'b0, (n < 8) ? 2'b01 : 2'b10, 1'b0}));
          n++;
          if (n == sa || n == sb2) st = slen;
        end
      end
      step();
      start = 1'b0;
      g++;
    end
    in_valid = 1'b0;
    chk("feed_count", 32'(n), 32'(nmax));
  endtask

  task automatic wait_done();
    exp_t e;
    int g = 0;
    while (!done && g < 400) begin
      step();
      g++;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(cyc - sc), 32'(e.lat));
    chk("busy_done", 32'(busy), 32'd0);
    chk("result_pc", 32'(result_pc), 32'(e.pc));
    chk("result_acc", 32'(result_acc), 32'(e.acc));
    chk("run_cycles", 32'(run_cycles), 32'(e.cycles));
    chk("halted", 32'(halted), 32'(e.halt));
    chk("done_ui", 32'(cpu_ui), 32'd0);
  endtask

  task automatic session(input logic [2:0] pc, input logic [7:0] lim,
                         input int sa, input int sb2, input int slen);
    do_start(pc, lim);
    feed(16, sa, sb2, slen, 1'b0);
    chk("rst1_ui", 32'(cpu_ui), 32'({1'b0, pc, 4'b0000}));
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    #1;
    chk("rst_ui", 32'(cpu_ui), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_rc", 32'(run_cycles), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("idle_rdy", 32'(in_ready), 32'd0);

    // Limit run.
    fill_add();
    push_exp(3'd5, 4'd5, 8'd5, 1'b0, 24);
    session(3'd0, 8'd5, -1, -1, 0);

    // Load stalls after nibbles 2 and 10.
    push_exp(3'd5, 4'd5, 8'd5, 1'b0, 30);
    session(3'd0, 8'd5, 2, 10, 3);

    // Halt on Bz-to-self.
    fill_halt();
`ifdef CPU4_SEQ_HALT_DETECT_EN
    push_exp(3'd1, 4'd0, 8'd3, 1'b1, 22);
`else
    push_exp(3'd1, 4'd0, 8'd20, 1'b0, 39);
`endif
    session(3'd0, 8'd20, -1, -1, 0);

    // Counter wrap: run_limit 0 means 256 Runs.
    fill_add();
    push_exp(3'd0, 4'd0, 8'd0, 1'b0, 275);
    session(3'd0, 8'd0, -1, -1, 0);

    // Non-zero entry pc.
    push_exp(3'd1, 4'd3, 8'd3, 1'b0, 22);
    session(3'd6, 8'd3, -1, -1, 0);

    // Abort during DATA with start held alongside reset.
    do_start(3'd0, 8'd5);
    feed(10, -1, -1, 0, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'hF;
    rst_n    = 1'b0;
    start    = 1'b1;
    #1;
    chk("abort_ui", 32'(cpu_ui), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rpc", 32'(result_pc), 32'd0);
    chk("abort_racc", 32'(result_acc), 32'd0);
    chk("abort_rc", 32'(run_cycles), 32'd0);
    chk("abort_halted", 32'(halted), 32'd0);

    // Fresh session; a start pulse mid-load must be ignored.
    push_exp(3'd5, 4'd5, 8'd5, 1'b0, 24);
    do_start(3'd0, 8'd5);
    feed(16, -1, -1, 0, 1'b1);
    chk("rst1_ui", 32'(cpu_ui), 32'd0);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
